binary_adder_pipe: RTL and testbench
====================================

Name: binary_adder_pipe

Overview:
- Parametrised, pipelined N-bit adder/subtractor with a registered result. Successor to the fixed-width ripple adder built from 4-bit slices.
- The carry chain is split into SLICE-bit stages, with one register boundary per stage. One operation is accepted per cycle, and each operation carries its own mode.
- Adds a valid handshake, a global stall (EN), signed overflow detection, and borrow semantics for subtraction.

Parameters:
- W, 16: operand and result width in bits.
- SLICE, 4: bits per pipeline stage. W % SLICE must be 0 and W >= SLICE, or elaboration fails.
- NSTAGES, W/SLICE: derived, not overridable. This is the pipeline depth.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  pipeline advance. 0 = every pipeline register and output holds.
- IN_VALID  in  1  A, B, Cin and MODO are valid this cycle.
- MODO  in  2  00 add, 01 subtract, 10 pass A, 11 increment A.
- A  in  W  operand A.
- B  in  W  operand B.
- Cin  in  1  carry-in for add; borrow-in for subtract.
- Q  out  W  registered result.
- RCO  out  1  carry-out for add/increment; borrow for subtract; 0 for pass.
- OVF  out  1  two's-complement overflow of the operation.
- OUT_VALID  out  1  Q, RCO and OVF carry a new result this cycle.

Behaviour:
- Reset: at a CLK edge with RESET=1, all stage valid bits, Q, RCO, OVF and OUT_VALID go to 0. RESET has priority over EN. In-flight operations are discarded, not completed.
- Operation definitions:
  - Add: {RCO,Q} = A + B + Cin.
  - Subtract: sum = A + ~B + ~Cin; Q = low W bits; RCO = ~carry_out. RCO=1 means A < B + Cin.
  - Pass: Q = A, RCO = 0, OVF = 0. B and Cin are ignored.
  - Increment: {RCO,Q} = A + 1. Cin and B are ignored.
- OVF for add, subtract and increment: (sign of operand A == sign of effective second operand) and (sign of Q != sign of A). The effective second operand is B, ~B or 0x1 respectively.
- Pipeline structure:
  - Stage k (0..NSTAGES-1) computes bits [k*SLICE +: SLICE] using the registered carry from stage k-1. Stage 0 uses the effective carry-in.
  - Upper operand slices are skew-delayed. Completed low result slices are de-skew-delayed, so every slice of one operation reaches Q together.
  - Mode and valid bits travel with their operation.
- Latency: an operation sampled with IN_VALID=1 and EN=1 at edge t appears with OUT_VALID=1 after edge t+NSTAGES-1, i.e. NSTAGES EN-qualified edges. With the defaults this is 4 cycles.
- Throughput: 1 operation per cycle while EN=1. Results leave in issue order.
- EN=0:
  - Inputs are not sampled; IN_VALID is ignored.
  - All stage registers hold.
  - Q, RCO and OVF hold. OUT_VALID holds its value, so a result is not re-presented as new: the consumer qualifies OUT_VALID with EN.
- IN_VALID=0 with EN=1: a bubble enters the pipeline. When the bubble reaches the output, OUT_VALID=0, and Q, RCO and OVF keep the last valid result.
- Width rules: no internal truncation other than the final W-bit wrap. 0xFFFF + 1 wraps to 0x0000 with RCO=1.
- RESET and IN_VALID together: reset wins and the operation is dropped.
- Boundary cases:
  - A full-width carry ripple crosses every stage boundary with no extra latency.
  - SLICE = W degenerates to a single registered adder with latency 1.

Decomposition:
- Shared package holds:
  - mode encodings: MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_PASS=2'b10, MODE_INC=2'b11.
  - the parameter legality check.
- One sub-module, adder_slice: a SLICE-bit combinational sum with carry-in/carry-out.
  - The top module instantiates NSTAGES of these and owns all pipeline, skew and valid registers.

Test Plan:
- Latency and basic add: W=16, MODO=00, A=0x00FF, B=0x0001, Cin=0, IN_VALID=1 for one cycle -> exactly 4 cycles later OUT_VALID=1, Q=0x0100, RCO=0, OVF=0. Next cycle OUT_VALID=0 and Q holds 0x0100.
- Full carry ripple and overflow:
  - add 0xFFFF+0x0000, Cin=1 -> Q=0x0000, RCO=1, OVF=0.
  - add 0x7FFF+0x0001 -> Q=0x8000, RCO=0, OVF=1.
- Subtract:
  - 0x0003-0x0005, Cin=0 -> Q=0xFFFE, RCO=1, OVF=0.
  - 0x8000-0x0001 -> Q=0x7FFF, RCO=0, OVF=1.
  - 0x0005-0x0005, Cin=1 -> Q=0xFFFF, RCO=1.
- Streaming with stall:
  - Input: 4 back-to-back operations (add, sub, pass 0x1234, inc 0xFFFF), with EN=0 for 2 cycles after the second is issued.
  - Expected: results arrive in order (inc gives Q=0x0000, RCO=1), first result at cycle 4, remaining results delayed by exactly 2 cycles, no duplicates while EN=0.
- Reset mid-flight: issue 3 operations, assert RESET for 1 cycle while they are in flight -> next edge Q=0, RCO=0, OVF=0, OUT_VALID=0; none of the 3 results ever appears.
- Parameter sweep: W=8/SLICE=4 (latency 2) and W=12/SLICE=12 (latency 1) -> 1000 random operations match a reference model. Elaboration with W=10/SLICE=4 must fail.

Source files
------------

// File: rtl/binary_adder_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encodings
// and the geometry legality check used at elaboration.
package binary_adder_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_PASS = 2'b10,
    MODE_INC  = 2'b11
  } mode_e;

  function automatic bit slice_cfg_ok(input int w, input int s);
    return (s > 0) && (w >= s) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One SLICE-bit segment of the pipelined carry chain: plain sum with
// carry-in and carry-out, no state.
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             c_i,
  output logic [SLICE-1:0] s_o,
  output logic             c_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, c_i};

endmodule

// File: rtl/binary_adder_pipe.sv
// Pipelined W-bit adder/subtractor: one SLICE-bit carry segment per stage,
// operand skew ahead of the chain and result de-skew behind it.
module binary_adder_pipe
  import binary_adder_pipe_pkg::*;
#(
  parameter int W     = 16,
  parameter int SLICE = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         EN,
  input  logic         IN_VALID,
  input  logic [1:0]   MODO,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] Q,
  output logic         RCO,
  output logic         OVF,
  output logic         OUT_VALID
);

  localparam int NSTAGES = W / SLICE;

  if (!slice_cfg_ok(W, SLICE)) begin : g_bad_cfg
    $fatal(1, "binary_adder_pipe: W must be a non-zero multiple of SLICE");
  end

  logic [W-1:0] b_eff_s;
  logic         cin_eff_s;

  // Map each mode onto a plain add: subtract uses ~B and ~Cin, pass adds zero
  always_comb begin
    b_eff_s   = B;
    cin_eff_s = Cin;
    case (mode_e'(MODO))
      MODE_ADD: begin
        b_eff_s   = B;
        cin_eff_s = Cin;
      end
      MODE_SUB: begin
        b_eff_s   = ~B;
        cin_eff_s = ~Cin;
      end
      MODE_PASS: begin
        b_eff_s   = {W{1'b0}};
        cin_eff_s = 1'b0;
      end
      MODE_INC: begin
        b_eff_s   = {W{1'b0}};
        cin_eff_s = 1'b1;
      end
      default: begin
        b_eff_s   = B;
        cin_eff_s = Cin;
      end
    endcase
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;
    localparam int HI = LO + SLICE;

    logic [W-1:LO]    a_up_s;
    logic [W-1:LO]    b_up_s;
    logic [HI-1:0]    res_s;
    logic [SLICE-1:0] sum_s;
    logic             c_in_s;
    logic             c_out_s;
    logic             vld_s;
    logic [1:0]       mode_s;

    if (k == 0) begin : g_src
      assign a_up_s = A;
      assign b_up_s = b_eff_s;
      assign c_in_s = cin_eff_s;
      assign mode_s = MODO;
      assign vld_s  = IN_VALID;
      assign res_s  = sum_s;
    end else begin : g_src
      assign a_up_s = g_stage[k-1].g_bank.a_q;
      assign b_up_s = g_stage[k-1].g_bank.b_q;
      assign c_in_s = g_stage[k-1].g_bank.c_q;
      assign mode_s = g_stage[k-1].g_bank.mode_q;
      assign vld_s  = g_stage[k-1].g_bank.vld_q;
      assign res_s  = {sum_s, g_stage[k-1].g_bank.res_q};
    end

    adder_slice #(.SLICE(SLICE)) u_slice (
      .a_i (a_up_s[HI-1:LO]),
      .b_i (b_up_s[HI-1:LO]),
      .c_i (c_in_s),
      .s_o (sum_s),
      .c_o (c_out_s)
    );

    if (k < NSTAGES - 1) begin : g_bank
      logic [W-1:HI] a_q;
      logic [W-1:HI] b_q;
      logic [HI-1:0] res_q;
      logic          c_q;
      logic          vld_q;
      logic [1:0]    mode_q;

      // Carry the untouched operand slices forward and the finished low slices behind
      always_ff @(posedge CLK) begin
        if (RESET) begin
          a_q    <= '0;
          b_q    <= '0;
          res_q  <= '0;
          c_q    <= 1'b0;
          vld_q  <= 1'b0;
          mode_q <= 2'b00;
        end else if (EN) begin
          a_q    <= a_up_s[W-1:HI];
          b_q    <= b_up_s[W-1:HI];
          res_q  <= res_s;
          c_q    <= c_out_s;
          vld_q  <= vld_s;
          mode_q <= mode_s;
        end
      end
    end
  end

  logic [W-1:0] last_res_s;
  logic [1:0]   last_mode_s;
  logic         last_c_s;
  logic         last_vld_s;
  logic         last_sa_s;
  logic         last_sb_s;
  logic         ovf_raw_s;
  logic         rco_d;
  logic         ovf_d;

  assign last_res_s  = g_stage[NSTAGES-1].res_s;
  assign last_mode_s = g_stage[NSTAGES-1].mode_s;
  assign last_c_s    = g_stage[NSTAGES-1].c_out_s;
  assign last_vld_s  = g_stage[NSTAGES-1].vld_s;
  assign last_sa_s   = g_stage[NSTAGES-1].a_up_s[W-1];
  assign last_sb_s   = g_stage[NSTAGES-1].b_up_s[W-1];

  // Carry becomes borrow for subtract; pass never reports carry or overflow
  always_comb begin
    rco_d     = 1'b0;
    ovf_d     = 1'b0;
    ovf_raw_s = (last_sa_s == last_sb_s) && (last_res_s[W-1] != last_sa_s);
    case (mode_e'(last_mode_s))
      MODE_ADD, MODE_INC: begin
        rco_d = last_c_s;
        ovf_d = ovf_raw_s;
      end
      MODE_SUB: begin
        rco_d = ~last_c_s;
        ovf_d = ovf_raw_s;
      end
      MODE_PASS: begin
        rco_d = 1'b0;
        ovf_d = 1'b0;
      end
      default: begin
        rco_d = 1'b0;
        ovf_d = 1'b0;
      end
    endcase
  end

  logic [W-1:0] q_q;
  logic         rco_q;
  logic         ovf_q;
  logic         out_valid_q;

  // Result register: bubbles clear OUT_VALID but leave the last result on Q
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q         <= '0;
      rco_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (EN) begin
      out_valid_q <= last_vld_s;
      if (last_vld_s) begin
        q_q   <= last_res_s;
        rco_q <= rco_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign Q         = q_q;
  assign RCO       = rco_q;
  assign OVF       = ovf_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_binary_adder_pipe.sv
// Scoreboard bench: directed vectors on the 16/4 pipe, plus a reference-model
// sweep on the 8/4 and 12/12 geometries sharing the clock, reset and stall.
module tb_binary_adder_pipe;
  import binary_adder_pipe_pkg::*;

  typedef struct {
    logic [31:0] v;
    int          at;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        EN;
  logic        IN_VALID;
  logic [1:0]  MODO;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic [15:0] Q;
  logic        RCO;
  logic        OVF;
  logic        OUT_VALID;

  logic        sw_valid;
  logic [1:0]  sw_mode;
  logic [11:0] sw_a;
  logic [11:0] sw_b;
  logic        sw_cin;
  logic [7:0]  q8;
  logic        rco8, ovf8, ov8;
  logic [11:0] q12;
  logic        rco12, ovf12, ov12;

  exp_t sb16[$];
  exp_t sb8[$];
  exp_t sb12[$];
  int   n_pass   = 0;
  int   n_total  = 0;
  int   en_edges = 0;
  logic en_seen  = 1'b0;

  always #5 CLK = ~CLK;

  binary_adder_pipe #(.W(16), .SLICE(4)) u_dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .IN_VALID(IN_VALID), .MODO(MODO),
    .A(A), .B(B), .Cin(Cin), .Q(Q), .RCO(RCO), .OVF(OVF), .OUT_VALID(OUT_VALID)
  );

  binary_adder_pipe #(.W(8), .SLICE(4)) u_w8 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .IN_VALID(sw_valid), .MODO(sw_mode),
    .A(sw_a[7:0]), .B(sw_b[7:0]), .Cin(sw_cin), .Q(q8), .RCO(rco8), .OVF(ovf8),
    .OUT_VALID(ov8)
  );

  binary_adder_pipe #(.W(12), .SLICE(12)) u_w12 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .IN_VALID(sw_valid), .MODO(sw_mode),
    .A(sw_a), .B(sw_b), .Cin(sw_cin), .Q(q12), .RCO(rco12), .OVF(ovf12),
    .OUT_VALID(ov12)
  );

  task automatic compare(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  // Signed/unsigned reference: carry from the unsigned result, overflow from signed range
  function automatic logic [31:0] model(input int w, input logic [1:0] m,
                                        input logic [15:0] ai, input logic [15:0] bi,
                                        input logic ci);
    longint modv, half, a, b, sa, sb, r, sr;
    logic   rco, ovf;
    modv = longint'(1) << w;
    half = modv / 2;
    a    = longint'(ai) % modv;
    b    = longint'(bi) % modv;
    sa   = (a >= half) ? a - modv : a;
    sb   = (b >= half) ? b - modv : b;
    case (m)
      2'b00: begin r = a + b + longint'(ci); sr = sa + sb + longint'(ci); rco = (r >= modv); end
      2'b01: begin r = a - b - longint'(ci); sr = sa - sb - longint'(ci); rco = (r < 0); end
      2'b11: begin r = a + 1; sr = sa + 1; rco = (r >= modv); end
      default: begin r = a; sr = 0; rco = 1'b0; end
    endcase
    ovf = (sr < -half) || (sr >= half);
    r   = ((r % modv) + modv) % modv;
    return {14'd0, rco, ovf, 16'(r)};
  endfunction

  always @(posedge CLK) begin
    en_seen <= EN;
    if (EN) en_edges <= en_edges + 1;
  end

  always @(negedge CLK) begin
    if (en_seen && OUT_VALID) begin
      compare("pending16", 32'(sb16.size() > 0), 32'd1);
      if (sb16.size() > 0) begin
        compare("res16", {14'd0, RCO, OVF, Q}, sb16[0].v);
        compare("edge16", en_edges, sb16[0].at);
        void'(sb16.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (en_seen && ov8) begin
      compare("pending8", 32'(sb8.size() > 0), 32'd1);
      if (sb8.size() > 0) begin
        compare("res8", {14'd0, rco8, ovf8, 8'd0, q8}, sb8[0].v);
        compare("edge8", en_edges, sb8[0].at);
        void'(sb8.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (en_seen && ov12) begin
      compare("pending12", 32'(sb12.size() > 0), 32'd1);
      if (sb12.size() > 0) begin
        compare("res12", {14'd0, rco12, ovf12, 4'd0, q12}, sb12[0].v);
        compare("edge12", en_edges, sb12[0].at);
        void'(sb12.pop_front());
      end
    end
  end

  task automatic drive16(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                         input logic c);
    @(negedge CLK);
    EN = 1'b1; IN_VALID = 1'b1; MODO = m; A = a; B = b; Cin = c;
  endtask

  task automatic issue16(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [15:0] eq, input logic er, input logic eo);
    drive16(m, a, b, c);
    sb16.push_back('{{14'd0, er, eo, eq}, en_edges + 4});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      EN = 1'b1; IN_VALID = 1'b0; sw_valid = 1'b0;
    end
  endtask

  initial begin
    RESET = 1'b1; EN = 1'b1; IN_VALID = 1'b1; MODO = MODE_ADD;
    A = 16'h1111; B = 16'h2222; Cin = 1'b0;
    sw_valid = 1'b0; sw_mode = 2'b00; sw_a = 12'd0; sw_b = 12'd0; sw_cin = 1'b0;
    repeat (3) @(negedge CLK);
    compare("rst_q", {16'd0, Q}, 32'd0);
    compare("rst_flags", {29'd0, RCO, OVF, OUT_VALID}, 32'd0);
    RESET = 1'b0; IN_VALID = 1'b0;

    // Latency and bubble hold
    issue16(MODE_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    @(negedge CLK); IN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    compare("lat_valid", {31'd0, OUT_VALID}, 32'd1);
    compare("lat_q", {16'd0, Q}, 32'h0100);
    @(negedge CLK);
    compare("bubble_valid", {31'd0, OUT_VALID}, 32'd0);
    compare("bubble_hold_q", {16'd0, Q}, 32'h0100);

    // Ripple, overflow and subtract, back to back
    issue16(MODE_ADD, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    issue16(MODE_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    issue16(MODE_SUB, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0);
    issue16(MODE_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    issue16(MODE_SUB, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    idle(6);

    // Reset mid-flight, asserted together with EN=0 and a new operation
    drive16(MODE_ADD, 16'h0F0F, 16'h0101, 1'b0);
    drive16(MODE_SUB, 16'h4000, 16'h0001, 1'b0);
    drive16(MODE_INC, 16'h1233, 16'h0000, 1'b0);
    @(negedge CLK); RESET = 1'b1; EN = 1'b0; IN_VALID = 1'b1; A = 16'hAAAA;
    @(negedge CLK);
    compare("midrst_q", {16'd0, Q}, 32'd0);
    compare("midrst_flags", {29'd0, RCO, OVF, OUT_VALID}, 32'd0);
    RESET = 1'b0; EN = 1'b1; IN_VALID = 1'b0;
    idle(6);

    // Streaming with a two-cycle stall; junk offered during the stall is ignored
    issue16(MODE_ADD, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    issue16(MODE_SUB, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge CLK); EN = 1'b0; IN_VALID = 1'b1; MODO = MODE_INC; A = 16'hBEEF;
    end
    issue16(MODE_PASS, 16'h1234, 16'hFFFF, 1'b1, 16'h1234, 1'b0, 1'b0);
    issue16(MODE_INC, 16'hFFFF, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);
    issue16(MODE_INC, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b1);
    issue16(MODE_PASS, 16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0);
    idle(6);

    // Geometry sweep against the reference model, with random stalls and bubbles
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      EN       = ($urandom_range(0, 9) != 0);
      sw_valid = ($urandom_range(0, 4) != 0);
      sw_mode  = 2'($urandom_range(0, 3));
      sw_a     = 12'($urandom());
      sw_b     = 12'($urandom());
      sw_cin   = 1'($urandom_range(0, 1));
      if (EN && sw_valid) begin
        sb8.push_back('{model(8, sw_mode, {4'd0, sw_a}, {4'd0, sw_b}, sw_cin), en_edges + 2});
        sb12.push_back('{model(12, sw_mode, {4'd0, sw_a}, {4'd0, sw_b}, sw_cin), en_edges + 1});
      end
    end
    idle(8);

    compare("drain16", sb16.size(), 32'd0);
    compare("drain8", sb8.size(), 32'd0);
    compare("drain12", sb12.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
